// File: rtl/dds_phase_gen.sv
// -----------------------------------------------------------------------------
// dds_phase_gen
//
// Direct digital synthesis phase generator. A phase accumulator advances by the
// active frequency tuning word once per rising edge of sample_clk, which comes
// from an upstream divider and is asynchronous to clk. Each step produces one
// registered waveform sample (saw, square, triangle or reverse saw) taken from
// the top OUT_W bits of the accumulator before that step's increment.
//
// A new tuning word is loaded with a load/ack handshake. The word is captured
// into a pending register at once, and becomes active only on the next sample
// tick, so a frequency change always lands on a sample boundary.
//
// Optional feature macro: DDS_PHASE_OFFSET_EN
//   When defined, adds the phase_offset input, which is registered every cycle
//   and added (mod 2^ACC_W) to the accumulator before truncation.
//
// Parameters
//   ACC_W        accumulator and tuning word width
//   OUT_W        waveform sample width, 2..ACC_W
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   sample_clk   divided sample clock, asynchronous to clk
//   ftw          frequency tuning word
//   ftw_load     load request, held high by the requester until ftw_ack
//   ftw_ack      one-cycle pulse: the requested word is now active
//   wave_sel     00 saw, 01 square, 10 triangle, 11 reverse saw
//   enable       accumulator run enable
//   phase_offset (DDS_PHASE_OFFSET_EN only) phase offset added before truncation
//   wave_out     registered waveform sample
//   wave_valid   one-cycle strobe marking a new wave_out
//   phase        current accumulator value
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dds_phase_gen #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_clk,
    input  logic [ACC_W-1:0] ftw,
    input  logic             ftw_load,
    output logic             ftw_ack,
    input  logic [1:0]       wave_sel,
    input  logic             enable,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [ACC_W-1:0] phase_offset,
`endif
    output logic [OUT_W-1:0] wave_out,
    output logic             wave_valid,
    output logic [ACC_W-1:0] phase
);

    typedef enum logic {
        HS_IDLE,
        HS_PENDING
    } hs_state_t;

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'b00,
        WAVE_SQUARE   = 2'b01,
        WAVE_TRIANGLE = 2'b10,
        WAVE_REV_SAW  = 2'b11
    } wave_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic             tick_q, tick_d;
    hs_state_t        state_q, state_d;
    logic [ACC_W-1:0] pending_q, pending_d;
    logic [ACC_W-1:0] active_q, active_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] wave_out_q, wave_out_d;
    logic             wave_valid_q, wave_valid_d;
    logic             ftw_ack_q, ftw_ack_d;
    logic [ACC_W-1:0] offset_val;
    logic [OUT_W-1:0] p;
    logic [OUT_W-1:0] tri_base;
    logic [OUT_W-1:0] wave_next;

`ifdef DDS_PHASE_OFFSET_EN
    logic [ACC_W-1:0] offset_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) offset_q <= '0;
        else       offset_q <= phase_offset;
    end

    assign offset_val = offset_q;
`else
    assign offset_val = '0;
`endif

    // ------------------------------------------------------------------
    // sample_clk synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = sample_clk;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        tick_d  = sync2_q & ~hist_q;
    end

    // ------------------------------------------------------------------
    // Waveform shaping from the pre-increment phase
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        p         = OUT_W'((acc_q + offset_val) >> (ACC_W - OUT_W));
        tri_base  = {p[OUT_W-2:0], 1'b0};
        wave_next = p;
        case (wave_t'(wave_sel))
            WAVE_SAW:      wave_next = p;
            WAVE_SQUARE:   wave_next = {OUT_W{p[OUT_W-1]}};
            // Doubling the phase and folding the upper half gives the falling
            // slope without a subtractor.
            WAVE_TRIANGLE: wave_next = p[OUT_W-1] ? ~tri_base : tri_base;
            WAVE_REV_SAW:  wave_next = ~p;
            default:       wave_next = p;
        endcase
    end

    // ------------------------------------------------------------------
    // Tuning word handshake and accumulator
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        active_d     = active_q;
        acc_d        = acc_q;
        wave_out_d   = wave_out_q;
        wave_valid_d = 1'b0;
        ftw_ack_d    = 1'b0;

        case (state_q)
            HS_IDLE: begin
                // In the ack cycle the requester still holds ftw_load; that
                // is the tail of the finished request, not a new one.
                if (ftw_load && !ftw_ack_q) begin
                    pending_d = ftw;
                    state_d   = HS_PENDING;
                end
            end
            HS_PENDING: begin
                if (tick_q) begin
                    active_d  = pending_q;
                    ftw_ack_d = 1'b1;
                    state_d   = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase

        // Increment uses active_q, i.e. the word in force before any swap
        // happening on this same tick.
        if (tick_q && enable) begin
            acc_d        = acc_q + active_q;
            wave_out_d   = wave_next;
            wave_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its inputs, independent of statement order.
        if (reset) begin
            // Synchroniser and edge history reset high: a sample_clk already
            // high at release must not look like a fresh rising edge.
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            hist_q       <= 1'b1;
            tick_q       <= 1'b0;
            state_q      <= HS_IDLE;
            pending_q    <= '0;
            active_q     <= '0;
            acc_q        <= '0;
            wave_out_q   <= '0;
            wave_valid_q <= 1'b0;
            ftw_ack_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            acc_q        <= acc_d;
            wave_out_q   <= wave_out_d;
            wave_valid_q <= wave_valid_d;
            ftw_ack_q    <= ftw_ack_d;
        end
    end

    assign ftw_ack    = ftw_ack_q;
    assign wave_out   = wave_out_q;
    assign wave_valid = wave_valid_q;
    assign phase      = acc_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_gen
//
// Self-checking bench for dds_phase_gen (ACC_W=24, OUT_W=8). A behavioural
// model tracks the accumulator, active word and pending request as plain
// integers; each sample_clk rising edge is one model step. Directed sequences
// cover the saw/square/triangle patterns, double load requests, reset in the
// middle of a handshake and (with DDS_PHASE_OFFSET_EN) the phase offset,
// followed by a randomised run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dds_phase_gen;

    localparam int ACC_W = 24;
    localparam int OUT_W = 8;
    localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_clk;
    logic [ACC_W-1:0] ftw;
    logic             ftw_load;
    logic             ftw_ack;
    logic [1:0]       wave_sel;
    logic             enable;
`ifdef DDS_PHASE_OFFSET_EN
    logic [ACC_W-1:0] phase_offset;
`endif
    logic [OUT_W-1:0] wave_out;
    logic             wave_valid;
    logic [ACC_W-1:0] phase;

    dds_phase_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_clk (sample_clk),
        .ftw        (ftw),
        .ftw_load   (ftw_load),
        .ftw_ack    (ftw_ack),
        .wave_sel   (wave_sel),
        .enable     (enable),
`ifdef DDS_PHASE_OFFSET_EN
        .phase_offset(phase_offset),
`endif
        .wave_out   (wave_out),
        .wave_valid (wave_valid),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    longint unsigned m_acc;
    longint unsigned m_active;
    longint unsigned m_pend_val;
    bit              m_pending;
    longint unsigned m_off;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Waveform value from the phase using plain arithmetic.
    function automatic int unsigned model_wave(longint unsigned acc,
                                               longint unsigned off, int sel);
        int unsigned p;
        int unsigned top;
        int unsigned half;
        p    = int'(((acc + off) % ACC_MOD) >> (ACC_W - OUT_W));
        top  = (1 << OUT_W) - 1;
        half = 1 << (OUT_W - 1);
        case (sel)
            0:       return p;
            1:       return (p >= half) ? top : 0;
            2:       return (p < half) ? 2 * p : top - 2 * (p - half);
            default: return top - p;
        endcase
    endfunction

    // Raise ftw_load with a word; the model captures it only when no request
    // is already outstanding.
    task automatic request(input int unsigned word);
        ftw      = word[ACC_W-1:0];
        ftw_load = 1'b1;
        if (!m_pending) begin
            m_pending  = 1'b1;
            m_pend_val = word;
        end
        repeat (2) @(negedge clk);
    endtask

    // One sample_clk period: raise, watch a bounded window for wave_valid and
    // ftw_ack, compare against the model, then lower and let the sync settle.
    task automatic do_tick(input string tag);
        int          n_valid = 0;
        int          n_ack   = 0;
        logic [31:0] got     = 'x;
        int unsigned exp_w;
        exp_w      = model_wave(m_acc, m_off, int'(wave_sel));
        sample_clk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wave_valid) begin
                n_valid++;
                got = 32'(wave_out);
            end
            if (ftw_ack) begin
                n_ack++;
                ftw_load = 1'b0;
            end
        end
        check({tag, " valid_cnt"}, n_valid, enable ? 1 : 0);
        check({tag, " ack_cnt"}, n_ack, m_pending ? 1 : 0);
        if (enable) begin
            check({tag, " wave_out"}, got, exp_w);
            m_acc = (m_acc + m_active) % ACC_MOD;
        end
        if (m_pending) begin
            m_active  = m_pend_val;
            m_pending = 1'b0;
        end
        check({tag, " phase"}, 32'(phase), 32'(m_acc));
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        sample_clk = 1'b0;
        ftw        = '0;
        ftw_load   = 1'b0;
        wave_sel   = 2'b00;
        enable     = 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
        phase_offset = '0;
`endif
        m_acc      = 0;
        m_active   = 0;
        m_pend_val = 0;
        m_pending  = 1'b0;
        m_off      = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst wave_out", 32'(wave_out), 0);
        check("rst wave_valid", 32'(wave_valid), 0);
        check("rst ftw_ack", 32'(ftw_ack), 0);
        check("rst phase", 32'(phase), 0);

        // Saw, 17 ticks through a full wrap; first tick still uses ftw 0
        wave_sel = 2'b00;
        enable   = 1'b1;
        request(32'h100000);
        for (int i = 0; i < 17; i++) do_tick("saw");
        check("saw wrap phase", 32'(phase), 0);

        // Square with ftw 0x400000
        enable = 1'b0;
        request(32'h400000);
        do_tick("sq load");
        wave_sel = 2'b01;
        enable   = 1'b1;
        for (int i = 0; i < 8; i++) do_tick("square");

        // Triangle with ftw 0x200000
        enable = 1'b0;
        request(32'h200000);
        do_tick("tri load");
        wave_sel = 2'b10;
        enable   = 1'b1;
        for (int i = 0; i < 8; i++) do_tick("triangle");

        // Second request while pending is ignored
        wave_sel = 2'b00;
        enable   = 1'b1;
        request(32'h010000);
        ftw = 24'h020000;
        repeat (3) @(negedge clk);
        do_tick("dbl ack");
        do_tick("dbl first word");
        request(32'h020000);
        do_tick("dbl reissue");
        do_tick("dbl second word");

        // Reset in the middle of a pending request with sample_clk high
        request(32'h123456);
        sample_clk = 1'b1;
        @(negedge clk);
        reset    = 1'b1;
        ftw_load = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        m_acc     = 0;
        m_active  = 0;
        m_pending = 1'b0;
        begin
            int n_valid = 0;
            int n_ack   = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (wave_valid) n_valid++;
                if (ftw_ack) n_ack++;
            end
            check("mid rst valid_cnt", n_valid, 0);
            check("mid rst ack_cnt", n_ack, 0);
            check("mid rst wave_out", 32'(wave_out), 0);
            check("mid rst phase", 32'(phase), 0);
        end
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
        do_tick("post rst 1");
        do_tick("post rst 2");

`ifdef DDS_PHASE_OFFSET_EN
        // Phase offset with a zero tuning word
        phase_offset = 24'h800000;
        m_off        = 64'h800000;
        wave_sel     = 2'b00;
        enable       = 1'b0;
        request(32'h0);
        do_tick("off load");
        enable = 1'b1;
        for (int i = 0; i < 4; i++) do_tick("offset");
`endif

        // Randomised run
        for (int i = 0; i < 40; i++) begin
            wave_sel = 2'($urandom_range(0, 3));
            enable   = ($urandom_range(0, 3) != 0);
`ifdef DDS_PHASE_OFFSET_EN
            if ($urandom_range(0, 3) == 0) begin
                phase_offset = 24'($urandom_range(0, (1 << ACC_W) - 1));
                m_off        = 64'(phase_offset);
            end
`endif
            if (!ftw_load && $urandom_range(0, 2) == 0)
                request($urandom_range(0, (1 << ACC_W) - 1));
            do_tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
